alu_seq: RTL
============

# alu_seq

Parametrised, sequential successor of the 8-bit combinational ALU. It adds a start/valid handshake, registered result and flags (N, Z, C, V), carry-chained add/sub, arithmetic shift, and iterative multi-cycle shift and multiply units. It sits between the register file and the shared data bus, and drives the bus through the same tri-state `ce` output enable.

## Interface
- `WIDTH`, 8, datapath width in bits; must be 4 or greater. `CNT_W = $clog2(WIDTH+1)` is derived, not overridable.
- `clk` in 1: single clock, rising edge.
- `i_nReset` in 1: asynchronous, active-low reset.
- `i_start` in 1: request. Sampled only when `o_busy`=0.
- `i_aluOp` in 3: operation select.
  - 000 add/sub
  - 001 and
  - 010 xor
  - 011 shift
  - 100 or
  - 101 mul
  - others: treated as and
- `i_sub` in 1: subtract, for op 000.
- `i_withCarry` in 1: op 000 uses the stored C flag as carry-in.
- `i_shiftLeft` in 1: shift direction; 1 = left.
- `i_arith` in 1: right shifts fill with the sign bit.
- `i_a`, `i_b` in WIDTH: operands. For shifts, `i_b` is the shift amount.
- `ce` in 1: output enable for `o_y`.
- `o_y` out WIDTH: result register when `ce`=1, all-Z when `ce`=0.
- `o_busy` out 1: multi-cycle operation in progress.
- `o_valid` out 1: one-cycle pulse when a result completes.
- `o_negative`, `o_zero`, `o_carry`, `o_overflow` out 1: registered flags.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE and DONE both accept `i_start`.
  - RUN ignores `i_start`.
- On accept, the block latches the operands and control inputs. Input changes afterwards have no effect until the next accept.
- Single-cycle ops go directly to DONE with the result and flags written:
  - add/sub, and, xor, or.
  - shift with `i_b`=0.
- Multi-cycle ops load the step counter and enter RUN:
  - Shift: count = min(`i_b`, WIDTH). One bit per cycle. Fill is 0, or the sign bit when `i_arith`=1 and the shift is right.
  - Mul: count = WIDTH. Shift-add per cycle. Result is the low WIDTH bits.
- RUN decrements the counter every cycle. The final step writes the result and flags, and the FSM moves to DONE.
- DONE lasts one cycle with `o_valid`=1, then goes to IDLE. If `i_start` is accepted in DONE, it goes to RUN or DONE instead.
- Add/sub arithmetic:
  - sum = a + (sub ? ~b : b) + cin.
  - cin = `i_withCarry` ? C : `i_sub`.
  - C = carry-out of the WIDTH-bit add (sub: C=1 means no borrow).
  - V = signed overflow.
- Logic ops: C=0, V=0.
- Shift: C = last bit shifted out (0 if the count is 0); V=0.
- Mul: C = 1 if the upper WIDTH bits of the full product are nonzero; V=0.
- N = MSB of the result; Z = (result == 0), for every op.
- Result and flags hold until the next completion.

## Timing
- Reset values:
  - State IDLE.
  - Result register 0, so `o_y`=0 when `ce`=1.
  - All flags 0, `o_busy`=0, `o_valid`=0, counter 0.
- Reset is effective immediately, including mid-RUN. The in-flight operation is discarded.
- `o_y` is combinational from `ce`. Z appears in the same cycle `ce` falls, with no clock needed.
- Latency, from the `i_start` sampling edge to the edge that first shows `o_valid`=1:
  - Single-cycle ops: 1 edge.
  - Shift by s (1 ≤ s ≤ WIDTH): s+1 edges. Shift amounts ≥ WIDTH clamp to WIDTH, giving 0 or full sign fill.
  - Mul: WIDTH+1 edges.
- `o_busy`=1 exactly during RUN. `o_valid` and `o_busy` are never high together.
- Back-to-back single-cycle ops give `o_valid` every cycle.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_t`, the 3-bit enum of the opcodes.
  - `alu_state_t` (IDLE/RUN/DONE).
  - Opcode constants shared with the decoder.
- Sub-module `alu_addsub`: combinational WIDTH-bit adder with inputs a, b, sub, cin and outputs sum, carry, overflow. It is reused by the mul accumulate step.
- Top level holds the FSM, counter, operand/shift registers, flag registers and the tri-state driver.

## Test plan
- Reset: pulse `i_nReset` low on the 3rd cycle of a shift by 5. Required response:
  - Immediately: `o_busy`=0, `o_valid`=0, all flags 0.
  - `o_y`=0 with `ce`=1.
- Add, WIDTH=8:
  - 20+22 gives 42, `o_valid` 1 edge after start.
  - 200+56 gives 0 with Z=1, C=1.
  - Then `i_withCarry`=1 with 0+0 gives 1.
- Sub:
  - 42-15 gives 27 with C=1.
  - 15-42 gives 0xE5 with N=1, C=0.
  - 0x80-1 gives 0x7F with V=1.
- Shift:
  - 0x2a<<3 gives 0x50, `o_valid` exactly 4 edges after start. An `i_start` issued while busy is ignored.
  - 0x2a<<5 gives 0x40 with C=1.
  - Arithmetic 0x80>>1 gives 0xC0.
  - Shift by 9 gives 0.
- Mul:
  - 13×11 gives 0x8F with C=0, latency 9 edges.
  - 20×20 gives 0x90 with C=1.
- Bus and width:
  - `ce`=0 gives `o_y`===Z during and after an op.
  - WIDTH=16: 0x7FFF+1 gives 0x8000 with V=1, N=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU and its decoder.
package alu_pkg;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_XOR   = 3'b010;
  localparam logic [2:0] ALU_SHIFT = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_MUL   = 3'b101;

  typedef enum logic [2:0] {
    OP_ADD   = ALU_ADD,
    OP_AND   = ALU_AND,
    OP_XOR   = ALU_XOR,
    OP_SHIFT = ALU_SHIFT,
    OP_OR    = ALU_OR,
    OP_MUL   = ALU_MUL
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;
endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed overflow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: start/valid handshake, registered result/flags, iterative shift
// and shift-add multiply, tri-state result drive onto the shared bus.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_nReset,
  input  logic             i_start,
  input  logic [2:0]       i_aluOp,
  input  logic             i_sub,
  input  logic             i_withCarry,
  input  logic             i_shiftLeft,
  input  logic             i_arith,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             ce,
  output logic [WIDTH-1:0] o_y,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_negative,
  output logic             o_zero,
  output logic             o_carry,
  output logic             o_overflow
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] B_FULL   = WIDTH'(WIDTH);

  alu_state_t       state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d, arith_q, arith_d;
  logic [WIDTH-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d, y_q, y_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic             valid_q, valid_d, busy_q, busy_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_sub, add_cin, add_c, add_v;
  logic [WIDTH-1:0] sh_next, mul_hi, mul_lo, res;
  logic             sh_out, res_c, res_v, wr;

  // The one adder serves add/sub at accept time and the accumulate step in RUN.
  always_comb begin
    if (state_q == S_RUN) begin
      add_a   = hi_q;
      add_b   = lo_q[0] ? a_q : '0;
      add_sub = 1'b0;
      add_cin = 1'b0;
    end else begin
      add_a   = i_a;
      add_b   = i_b;
      add_sub = i_sub;
      add_cin = i_withCarry ? c_q : i_sub;
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(add_a), .b(add_b), .sub(add_sub), .cin(add_cin),
    .sum(add_sum), .carry(add_c), .overflow(add_v)
  );

  always_comb begin
    if (left_q) begin
      sh_next = {a_q[WIDTH-2:0], 1'b0};
      sh_out  = a_q[WIDTH-1];
    end else begin
      sh_next = {arith_q & a_q[WIDTH-1], a_q[WIDTH-1:1]};
      sh_out  = a_q[0];
    end
    // {carry, sum, lo} shifted right one place: product builds from the top down.
    mul_hi = {add_c, add_sum[WIDTH-1:1]};
    mul_lo = {add_sum[0], lo_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;  op_d = op_q;    cnt_d = cnt_q;
    left_d  = left_q;   arith_d = arith_q;
    a_d = a_q;  hi_d = hi_q;  lo_d = lo_q;  y_d = y_q;
    n_d = n_q;  z_d = z_q;    c_d = c_q;    v_d = v_q;
    valid_d = 1'b0;
    wr = 1'b0;  res = '0;  res_c = 1'b0;  res_v = 1'b0;
    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          hi_d = mul_hi;
          lo_d = mul_lo;
        end else begin
          a_d = sh_next;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          wr      = 1'b1;
          res     = (op_q == OP_MUL) ? mul_lo : sh_next;
          res_c   = (op_q == OP_MUL) ? |mul_hi : sh_out;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (i_start) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          wr      = 1'b1;
          case (i_aluOp)
            OP_ADD: begin
              res   = add_sum;
              res_c = add_c;
              res_v = add_v;
            end
            OP_XOR: res = i_a ^ i_b;
            OP_OR:  res = i_a | i_b;
            OP_SHIFT: begin
              if (i_b == '0) begin
                res = i_a;
              end else begin
                wr      = 1'b0;
                valid_d = 1'b0;
                state_d = S_RUN;
                op_d    = OP_SHIFT;
                a_d     = i_a;
                left_d  = i_shiftLeft;
                arith_d = i_arith;
                cnt_d   = (i_b >= B_FULL) ? CNT_FULL : i_b[CNT_W-1:0];
              end
            end
            OP_MUL: begin
              wr      = 1'b0;
              valid_d = 1'b0;
              state_d = S_RUN;
              op_d    = OP_MUL;
              a_d     = i_a;
              hi_d    = '0;
              lo_d    = i_b;
              cnt_d   = CNT_FULL;
            end
            default: res = i_a & i_b;
          endcase
        end
      end
    endcase
    if (wr) begin
      y_d = res;
      n_d = res[WIDTH-1];
      z_d = (res == '0);
      c_d = res_c;
      v_d = res_v;
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q <= S_IDLE;  op_q <= OP_ADD;  cnt_q <= '0;
      left_q  <= 1'b0;    arith_q <= 1'b0;
      a_q <= '0;  hi_q <= '0;  lo_q <= '0;  y_q <= '0;
      n_q <= 1'b0;  z_q <= 1'b0;  c_q <= 1'b0;  v_q <= 1'b0;
      valid_q <= 1'b0;  busy_q <= 1'b0;
    end else begin
      state_q <= state_d;  op_q <= op_d;  cnt_q <= cnt_d;
      left_q  <= left_d;   arith_q <= arith_d;
      a_q <= a_d;  hi_q <= hi_d;  lo_q <= lo_d;  y_q <= y_d;
      n_q <= n_d;  z_q <= z_d;  c_q <= c_d;  v_q <= v_d;
      valid_q <= valid_d;  busy_q <= busy_d;
    end
  end

  assign o_y        = ce ? y_q : {WIDTH{1'bz}};
  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_negative = n_q;
  assign o_zero     = z_q;
  assign o_carry    = c_q;
  assign o_overflow = v_q;
endmodule
